// File: rtl/fta_to_wb_bridge.sv
// fta_to_wb_bridge: FTA responder that replays queued requests as Wishbone
// classic-cycle transfers and answers each beat with a tid-tagged FTA response.
// Reads run blen+1 beats; writes always run a single beat.
// Optional feature macro: FTA2WB_RETRY_EN. When it is defined, the bridge
// reissues a beat itself on wb_rty_i, up to MAX_RETRY times. When it is
// undefined, the retry is passed back to the initiator as fta_rty.
module fta_to_wb_bridge #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3,
    localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fta_cyc,
    input  logic                  fta_stb,
    input  logic                  fta_we,
    input  logic [ADDR_WIDTH-1:0] fta_adr,
    input  logic [SEL_WIDTH-1:0]  fta_sel,
    input  logic [DATA_WIDTH-1:0] fta_dat,
    input  logic [12:0]           fta_tid,
    input  logic [7:0]            fta_blen,
    output logic                  fta_stall,
    output logic                  fta_ack,
    output logic                  fta_err,
    output logic                  fta_rty,
    output logic [12:0]           fta_resp_tid,
    output logic [ADDR_WIDTH-1:0] fta_resp_adr,
    output logic [DATA_WIDTH-1:0] fta_resp_dat,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i
);
    localparam int                    PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]        FULL_CNT   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]        CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
    localparam logic [7:0]            TMO_LIMIT  = 8'(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(SEL_WIDTH);
`ifdef FTA2WB_RETRY_EN
    localparam int                    RTY_W      = $clog2(MAX_RETRY + 2);
    localparam logic [RTY_W-1:0]      RTY_LIMIT  = RTY_W'(MAX_RETRY);
`endif

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] dat;
        logic [12:0]           tid;
        logic [7:0]            blen;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_BUS, S_NEXT, S_RETRY
    } state_t;

    // Request queue
    req_t             fifo_mem [FIFO_DEPTH];
    req_t             req_in, head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    // Sequencer state
    state_t                state_q;
    logic [7:0]            beats_q;
    logic [7:0]            tmo_q;
    logic [12:0]           tid_q;
`ifdef FTA2WB_RETRY_EN
    logic [RTY_W-1:0]      rty_cnt_q;
`endif
    logic                  wb_cyc_q, wb_stb_q, wb_we_q;
    logic [ADDR_WIDTH-1:0] wb_adr_q;
    logic [SEL_WIDTH-1:0]  wb_sel_q;
    logic [DATA_WIDTH-1:0] wb_dat_q;
    logic                  fta_ack_q, fta_err_q, fta_rty_q;
    logic [12:0]           resp_tid_q;
    logic [ADDR_WIDTH-1:0] resp_adr_q;
    logic [DATA_WIDTH-1:0] resp_dat_q;

    // Stall comes from the registered count only, so it never depends on this cycle's pop.
    assign fta_stall = (count_q == FULL_CNT);
    assign push      = fta_cyc & fta_stb & ~fta_stall;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign req_in    = {fta_we, fta_adr, fta_sel, fta_dat, fta_tid, fta_blen};
    assign head      = fifo_mem[rd_ptr_q];

    assign wb_cyc_o     = wb_cyc_q;
    assign wb_stb_o     = wb_stb_q;
    assign wb_we_o      = wb_we_q;
    assign wb_adr_o     = wb_adr_q;
    assign wb_sel_o     = wb_sel_q;
    assign wb_dat_o     = wb_dat_q;
    assign fta_ack      = fta_ack_q;
    assign fta_err      = fta_err_q;
    assign fta_rty      = fta_rty_q;
    assign fta_resp_tid = resp_tid_q;
    assign fta_resp_adr = resp_adr_q;
    assign fta_resp_dat = resp_dat_q;

    // Next queue pointers and occupancy; a push and a pop together cancel out
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    // Queue pointer/count registers; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= req_in;
    end

    // Sequencer: pops a request, drives Wishbone beats, issues one-cycle FTA responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            tmo_q      <= '0;
            tid_q      <= '0;
`ifdef FTA2WB_RETRY_EN
            rty_cnt_q  <= '0;
`endif
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_adr_q   <= '0;
            wb_sel_q   <= '0;
            wb_dat_q   <= '0;
            fta_ack_q  <= 1'b0;
            fta_err_q  <= 1'b0;
            fta_rty_q  <= 1'b0;
            resp_tid_q <= '0;
            resp_adr_q <= '0;
            resp_dat_q <= '0;
        end else begin
            fta_ack_q <= 1'b0;
            fta_err_q <= 1'b0;
            fta_rty_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        wb_we_q  <= head.we;
                        wb_adr_q <= head.adr;
                        wb_sel_q <= head.sel;
                        wb_dat_q <= head.dat;
                        tid_q    <= head.tid;
                        beats_q  <= head.we ? 8'd0 : head.blen;
                        state_q  <= S_LOAD;
                    end
                end
                // One cycle between popping the entry and raising the cycle
                S_LOAD: begin
                    wb_cyc_q  <= 1'b1;
                    wb_stb_q  <= 1'b1;
                    tmo_q     <= '0;
`ifdef FTA2WB_RETRY_EN
                    rty_cnt_q <= '0;
`endif
                    state_q   <= S_BUS;
                end
                S_BUS: begin
                    if (wb_ack_i) begin
                        fta_ack_q  <= 1'b1;
                        resp_tid_q <= tid_q;
                        resp_adr_q <= wb_adr_q;
                        resp_dat_q <= wb_we_q ? '0 : wb_dat_i;
                        wb_stb_q   <= 1'b0;
                        state_q    <= S_NEXT;
                    end else if (wb_err_i) begin
                        fta_err_q  <= 1'b1;
                        resp_tid_q <= tid_q;
                        resp_adr_q <= wb_adr_q;
                        resp_dat_q <= '0;
                        wb_cyc_q   <= 1'b0;
                        wb_stb_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (wb_rty_i) begin
                        resp_tid_q <= tid_q;
                        resp_adr_q <= wb_adr_q;
                        resp_dat_q <= '0;
                        wb_stb_q   <= 1'b0;
                        wb_cyc_q   <= 1'b0;
`ifdef FTA2WB_RETRY_EN
                        if (rty_cnt_q == RTY_LIMIT) begin
                            fta_err_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            rty_cnt_q <= rty_cnt_q + RTY_W'(1);
                            state_q   <= S_RETRY;
                        end
`else
                        fta_rty_q  <= 1'b1;
                        state_q    <= S_IDLE;
`endif
                    end else if (tmo_q == TMO_LIMIT) begin
                        fta_err_q  <= 1'b1;
                        resp_tid_q <= tid_q;
                        resp_adr_q <= wb_adr_q;
                        resp_dat_q <= '0;
                        wb_cyc_q   <= 1'b0;
                        wb_stb_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (tmo_q != 8'hFF) begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                // stb gap between beats; cyc drops only after the final beat
                S_NEXT: begin
                    if (beats_q == 8'd0) begin
                        wb_cyc_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        beats_q   <= beats_q - 8'd1;
                        wb_adr_q  <= wb_adr_q + BEAT_BYTES;
                        tmo_q     <= '0;
`ifdef FTA2WB_RETRY_EN
                        rty_cnt_q <= '0;
`endif
                        wb_stb_q  <= 1'b1;
                        state_q   <= S_BUS;
                    end
                end
                // Cycle was dropped for one clock; reissue the same beat
                S_RETRY: begin
                    wb_cyc_q <= 1'b1;
                    wb_stb_q <= 1'b1;
                    tmo_q    <= '0;
                    state_q  <= S_BUS;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
